serv_wb_arbiter: RTL and testbench
==================================

Name: serv_wb_arbiter

Overview:
- Shares one Wishbone master port between the SERV core instruction bus and data bus.
- Sits between the core top level and the single memory/peripheral interconnect.
- Sequences one transaction at a time: latches the grant and the request fields, waits for the slave ack, and returns a registered ack and read data to the granted requester.
- A watchdog terminates hung transactions with an error response.

Parameters:
- TIMEOUT, 255, slave cycles allowed before forced termination; 0 disables the watchdog.
- ERR_DATA, 32'hDEADBEEF, read data returned on a timed-out transaction.

Ports:
- clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_ibus_adr  in  32  instruction fetch address
- i_ibus_cyc  in  1  instruction request
- o_ibus_rdt  out  32  instruction read data
- o_ibus_ack  out  1  instruction ack, one-cycle pulse
- i_dbus_adr  in  32  data address
- i_dbus_dat  in  32  write data
- i_dbus_sel  in  4  byte enables
- i_dbus_we  in  1  write enable
- i_dbus_cyc  in  1  data request
- o_dbus_rdt  out  32  data read data
- o_dbus_ack  out  1  data ack, one-cycle pulse
- o_wb_adr  out  32  shared bus address
- o_wb_dat  out  32  shared bus write data
- o_wb_sel  out  4  shared bus byte enables
- o_wb_we  out  1  shared bus write enable
- o_wb_cyc  out  1  shared bus cycle/strobe
- i_wb_rdt  in  32  shared bus read data
- i_wb_ack  in  1  shared bus ack
- o_bus_err  out  1  one-cycle pulse on watchdog termination

Behaviour:
- Clock and reset: single clock domain. Reset is asynchronous and active-low.
- Reset values: every output 0; state IDLE; last_grant = DBUS, so the first tie goes to ibus; watchdog counter 0.
- States: IDLE, IBUS, DBUS, RESP.
- IDLE:
  - Only i_dbus_cyc high -> DBUS.
  - Only i_ibus_cyc high -> IBUS.
  - Both high -> grant the requester not in last_grant (round-robin).
  - On entry to IBUS/DBUS: register o_wb_adr/dat/sel/we from the granted requester, set o_wb_cyc=1, update last_grant, clear the counter.
  - For ibus: o_wb_we=0, o_wb_sel=4'hF, o_wb_dat=0.
- IBUS/DBUS:
  - o_wb_cyc held high; registered address/data fields stable for the whole transaction, even if requester inputs change.
  - On i_wb_ack: capture i_wb_rdt into the granted requester's rdt register, pulse its ack next cycle, drop o_wb_cyc, go to RESP.
  - Without ack: increment the counter.
  - If TIMEOUT != 0 and counter == TIMEOUT-1 with no ack: rdt = ERR_DATA, ack pulse, o_bus_err pulse, drop o_wb_cyc, go to RESP.
  - An ack in the same cycle as expiry wins: normal response, no error.
- RESP:
  - Exactly one cycle, with ack (and optionally o_bus_err) high and o_wb_cyc low.
  - Requester cyc inputs are ignored in this cycle (the requester is still presenting its request). Unconditionally -> IDLE.
- Latency:
  - Request sampled in IDLE at cycle N -> o_wb_cyc high at N+1.
  - Slave ack at cycle M -> requester ack at M+1.
  - Earliest next grant evaluated at M+2.
  - Minimum transaction: 3 cycles from request to ack (slave acks first cycle of cyc).
- Other rules:
  - rdt registers hold their value until the next response to the same requester.
  - i_wb_ack while in IDLE or RESP (stray or late ack) is ignored.
  - The non-granted requester never sees ack. Its request stays pending and is granted from IDLE after the current response.
  - Reset asserted mid-transaction clears o_wb_cyc and acks immediately (asynchronously). No response is delivered.
  - Counter width = $clog2(TIMEOUT+1), minimum 1.

Decomposition:
- Shared package serv_wb_pkg:
  - state enum (IDLE, IBUS, DBUS, RESP);
  - grant encoding constants GNT_IBUS/GNT_DBUS;
  - default ERR_DATA.
- One natural sub-module: serv_wb_watchdog, holding the counter, clear/enable inputs and expire output, parameterised by TIMEOUT.
- Arbitration and muxing stay in the top block.

Test Plan:
- Single ibus read: ibus_cyc at adr 0x100, slave acks 2 cycles after cyc with 0x00000013 -> o_wb_adr=0x100, we=0, sel=F. o_ibus_ack one pulse, one cycle after slave ack, with rdt=0x00000013. o_dbus_ack stays 0.
- dbus write: adr 0x2004, dat 0xCAFEF00D, sel 4'b0011, we=1 -> o_wb fields match. Inputs changed to 0 during the transaction do not alter o_wb fields. o_dbus_ack pulses once.
- Simultaneous requests from reset, both held -> ibus granted first, then dbus granted at IDLE after the ibus RESP. Repeat both -> alternation ibus, dbus, ibus.
- Watchdog: TIMEOUT=4, slave never acks -> o_wb_cyc high exactly 4 cycles. o_dbus_ack and o_bus_err pulse together, with rdt=0xDEADBEEF. Then a later stray i_wb_ack in IDLE produces no ack.
- Ack on expiry cycle: TIMEOUT=4, ack in the 4th cycle with 0x12345678 -> normal rdt 0x12345678, o_bus_err stays 0.
- Reset mid-transaction: i_rst_n low while o_wb_cyc=1 -> o_wb_cyc and all acks 0 within the same cycle. After release with no requests: IDLE, no ack. First tie goes to ibus.

Source files
------------

// File: rtl/serv_wb_pkg.sv
// Shared types and constants for the SERV Wishbone arbiter.
package serv_wb_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_IBUS = 2'd1;
  localparam logic [1:0] ST_DBUS = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    IBUS = ST_IBUS,
    DBUS = ST_DBUS,
    RESP = ST_RESP
  } state_t;

  localparam logic GNT_IBUS = 1'b0;
  localparam logic GNT_DBUS = 1'b1;

  localparam logic [31:0] DEFAULT_ERR_DATA = 32'hDEADBEEF;

  // Watchdog counter width: enough to hold TIMEOUT, never below one bit.
  function automatic int cnt_width(input int unsigned t);
    return (t == 0) ? 1 : $clog2(t + 1);
  endfunction

endpackage

// File: rtl/serv_wb_arbiter_if.sv
// Bus bundle between SERV core, arbiter and shared Wishbone interconnect.
// Signal names are from the arbiter's point of view (i_ = into arbiter).
interface serv_wb_arbiter_if;

  logic [31:0] i_ibus_adr;
  logic        i_ibus_cyc;
  logic [31:0] o_ibus_rdt;
  logic        o_ibus_ack;

  logic [31:0] i_dbus_adr;
  logic [31:0] i_dbus_dat;
  logic [3:0]  i_dbus_sel;
  logic        i_dbus_we;
  logic        i_dbus_cyc;
  logic [31:0] o_dbus_rdt;
  logic        o_dbus_ack;

  logic [31:0] o_wb_adr;
  logic [31:0] o_wb_dat;
  logic [3:0]  o_wb_sel;
  logic        o_wb_we;
  logic        o_wb_cyc;
  logic [31:0] i_wb_rdt;
  logic        i_wb_ack;

  logic        o_bus_err;

  // Arbiter side.
  modport slave (
    input  i_ibus_adr, i_ibus_cyc,
    output o_ibus_rdt, o_ibus_ack,
    input  i_dbus_adr, i_dbus_dat, i_dbus_sel, i_dbus_we, i_dbus_cyc,
    output o_dbus_rdt, o_dbus_ack,
    output o_wb_adr, o_wb_dat, o_wb_sel, o_wb_we, o_wb_cyc,
    input  i_wb_rdt, i_wb_ack,
    output o_bus_err
  );

  // Environment side: core requesters plus the shared slave.
  modport master (
    output i_ibus_adr, i_ibus_cyc,
    input  o_ibus_rdt, o_ibus_ack,
    output i_dbus_adr, i_dbus_dat, i_dbus_sel, i_dbus_we, i_dbus_cyc,
    input  o_dbus_rdt, o_dbus_ack,
    input  o_wb_adr, o_wb_dat, o_wb_sel, o_wb_we, o_wb_cyc,
    output i_wb_rdt, i_wb_ack,
    input  o_bus_err
  );

endinterface

// File: rtl/serv_wb_watchdog.sv
// Transaction watchdog: counts slave cycles without ack and flags expiry
// on the TIMEOUT-th cycle. TIMEOUT = 0 disables it.
module serv_wb_watchdog
  import serv_wb_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  localparam int CW = cnt_width(TIMEOUT);
  localparam logic [CW-1:0] LAST = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);

  logic [CW-1:0] r_cnt;

  // Count waiting cycles; cleared between transactions, saturates at expiry.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && !o_expire && (TIMEOUT != 0)) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_expire = (TIMEOUT != 0) && i_en && (r_cnt == LAST);

endmodule

// File: rtl/serv_wb_arbiter.sv
// Round-robin arbiter sharing one Wishbone master port between the SERV
// instruction and data buses, one transaction at a time, with a watchdog.
module serv_wb_arbiter
  import serv_wb_pkg::*;
#(
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = DEFAULT_ERR_DATA
) (
  input logic               clk,
  input logic               i_rst_n,
  serv_wb_arbiter_if.slave  bus
);

  state_t      r_state;
  logic        r_last_gnt;

  logic [31:0] r_wb_adr;
  logic [31:0] r_wb_dat;
  logic [3:0]  r_wb_sel;
  logic        r_wb_we;
  logic        r_wb_cyc;

  logic [31:0] r_ibus_rdt;
  logic        r_ibus_ack;
  logic [31:0] r_dbus_rdt;
  logic        r_dbus_ack;
  logic        r_bus_err;

  logic        w_gnt_ibus;
  logic        w_gnt_dbus;
  logic        w_busy;
  logic        w_expire;

  // On a tie, ibus wins unless it was the last one served.
  always_comb begin
    w_gnt_ibus = bus.i_ibus_cyc && (!bus.i_dbus_cyc || (r_last_gnt == GNT_DBUS));
    w_gnt_dbus = bus.i_dbus_cyc && !w_gnt_ibus;
  end

  assign w_busy = (r_state == IBUS) || (r_state == DBUS);

  serv_wb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk      (clk),
    .i_rst_n  (i_rst_n),
    .i_clr    (r_state == IDLE),
    .i_en     (w_busy),
    .o_expire (w_expire)
  );

  // Transaction sequencer: grant, hold the bus, return registered response.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= IDLE;
      r_last_gnt <= GNT_DBUS;
      r_wb_adr   <= '0;
      r_wb_dat   <= '0;
      r_wb_sel   <= '0;
      r_wb_we    <= 1'b0;
      r_wb_cyc   <= 1'b0;
      r_ibus_rdt <= '0;
      r_ibus_ack <= 1'b0;
      r_dbus_rdt <= '0;
      r_dbus_ack <= 1'b0;
      r_bus_err  <= 1'b0;
    end else begin
      r_ibus_ack <= 1'b0;
      r_dbus_ack <= 1'b0;
      r_bus_err  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_gnt_ibus) begin
            r_wb_adr   <= bus.i_ibus_adr;
            r_wb_dat   <= '0;
            r_wb_sel   <= '1;
            r_wb_we    <= 1'b0;
            r_wb_cyc   <= 1'b1;
            r_last_gnt <= GNT_IBUS;
            r_state    <= IBUS;
          end else if (w_gnt_dbus) begin
            r_wb_adr   <= bus.i_dbus_adr;
            r_wb_dat   <= bus.i_dbus_dat;
            r_wb_sel   <= bus.i_dbus_sel;
            r_wb_we    <= bus.i_dbus_we;
            r_wb_cyc   <= 1'b1;
            r_last_gnt <= GNT_DBUS;
            r_state    <= DBUS;
          end
        end
        IBUS, DBUS: begin
          // A slave ack on the expiry cycle takes precedence over the error.
          if (bus.i_wb_ack || w_expire) begin
            if (r_state == IBUS) begin
              r_ibus_rdt <= bus.i_wb_ack ? bus.i_wb_rdt : ERR_DATA;
              r_ibus_ack <= 1'b1;
            end else begin
              r_dbus_rdt <= bus.i_wb_ack ? bus.i_wb_rdt : ERR_DATA;
              r_dbus_ack <= 1'b1;
            end
            r_bus_err <= !bus.i_wb_ack;
            r_wb_cyc  <= 1'b0;
            r_state   <= RESP;
          end
        end
        RESP: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.o_wb_adr   = r_wb_adr;
  assign bus.o_wb_dat   = r_wb_dat;
  assign bus.o_wb_sel   = r_wb_sel;
  assign bus.o_wb_we    = r_wb_we;
  assign bus.o_wb_cyc   = r_wb_cyc;
  assign bus.o_ibus_rdt = r_ibus_rdt;
  assign bus.o_ibus_ack = r_ibus_ack;
  assign bus.o_dbus_rdt = r_dbus_rdt;
  assign bus.o_dbus_ack = r_dbus_ack;
  assign bus.o_bus_err  = r_bus_err;

endmodule

// File: tb/tb_serv_wb_arbiter.sv
// Directed bench for serv_wb_arbiter with TIMEOUT=4.
module tb_serv_wb_arbiter;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_bad;
  int   n_hi;

  serv_wb_arbiter_if bus();

  serv_wb_arbiter #(
    .TIMEOUT  (4),
    .ERR_DATA (32'hDEADBEEF)
  ) dut (
    .clk     (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // Advance to just after the next active edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic slave_ack(input logic [31:0] d);
    bus.i_wb_ack = 1'b1;
    bus.i_wb_rdt = d;
    step();
    bus.i_wb_ack = 1'b0;
    bus.i_wb_rdt = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    n_chk = 0;
    n_bad = 0;
    bus.i_ibus_adr = '0; bus.i_ibus_cyc = 1'b0;
    bus.i_dbus_adr = '0; bus.i_dbus_dat = '0; bus.i_dbus_sel = '0;
    bus.i_dbus_we  = 1'b0; bus.i_dbus_cyc = 1'b0;
    bus.i_wb_rdt   = '0; bus.i_wb_ack = 1'b0;
    rst_n = 1'b0;
    step();
    step();

    // Reset state
    chk("rst_cyc",   32'(bus.o_wb_cyc),   32'd0);
    chk("rst_iack",  32'(bus.o_ibus_ack), 32'd0);
    chk("rst_dack",  32'(bus.o_dbus_ack), 32'd0);
    chk("rst_err",   32'(bus.o_bus_err),  32'd0);
    chk("rst_adr",   bus.o_wb_adr,        32'd0);
    chk("rst_irdt",  bus.o_ibus_rdt,      32'd0);
    chk("rst_drdt",  bus.o_dbus_rdt,      32'd0);
    rst_n = 1'b1;

    // Single ibus read, slave acks on the second cycle of cyc
    bus.i_ibus_adr = 32'h100; bus.i_ibus_cyc = 1'b1;
    step();
    chk("ird_cyc", 32'(bus.o_wb_cyc), 32'd1);
    chk("ird_adr", bus.o_wb_adr,      32'h100);
    chk("ird_we",  32'(bus.o_wb_we),  32'd0);
    chk("ird_sel", 32'(bus.o_wb_sel), 32'hF);
    chk("ird_dat", bus.o_wb_dat,      32'd0);
    step();
    chk("ird_noack", 32'(bus.o_ibus_ack), 32'd0);
    slave_ack(32'h00000013);
    bus.i_ibus_cyc = 1'b0;
    chk("ird_ack",   32'(bus.o_ibus_ack), 32'd1);
    chk("ird_rdt",   bus.o_ibus_rdt,      32'h13);
    chk("ird_dack",  32'(bus.o_dbus_ack), 32'd0);
    chk("ird_cyc0",  32'(bus.o_wb_cyc),   32'd0);
    step();
    chk("ird_ack1",  32'(bus.o_ibus_ack), 32'd0);
    chk("ird_hold",  bus.o_ibus_rdt,      32'h13);
    step();
    chk("ird_idle",  32'(bus.o_wb_cyc),   32'd0);

    // dbus write, requester fields change mid-transaction
    bus.i_dbus_adr = 32'h2004; bus.i_dbus_dat = 32'hCAFEF00D;
    bus.i_dbus_sel = 4'b0011;  bus.i_dbus_we = 1'b1; bus.i_dbus_cyc = 1'b1;
    step();
    chk("dwr_adr", bus.o_wb_adr,      32'h2004);
    chk("dwr_dat", bus.o_wb_dat,      32'hCAFEF00D);
    chk("dwr_sel", 32'(bus.o_wb_sel), 32'h3);
    chk("dwr_we",  32'(bus.o_wb_we),  32'd1);
    bus.i_dbus_adr = '0; bus.i_dbus_dat = '0; bus.i_dbus_sel = '0; bus.i_dbus_we = 1'b0;
    step();
    chk("dwr_adr_hold", bus.o_wb_adr,      32'h2004);
    chk("dwr_dat_hold", bus.o_wb_dat,      32'hCAFEF00D);
    chk("dwr_sel_hold", 32'(bus.o_wb_sel), 32'h3);
    chk("dwr_we_hold",  32'(bus.o_wb_we),  32'd1);
    slave_ack(32'h00000055);
    bus.i_dbus_cyc = 1'b0;
    chk("dwr_ack",  32'(bus.o_dbus_ack), 32'd1);
    chk("dwr_iack", 32'(bus.o_ibus_ack), 32'd0);
    chk("dwr_irdt", bus.o_ibus_rdt,      32'h13);
    step();
    chk("dwr_ack1", 32'(bus.o_dbus_ack), 32'd0);
    step();

    // Simultaneous requests from reset: ibus, dbus, ibus
    do_reset();
    bus.i_ibus_adr = 32'h200;  bus.i_ibus_cyc = 1'b1;
    bus.i_dbus_adr = 32'h3000; bus.i_dbus_we = 1'b0; bus.i_dbus_sel = 4'hF;
    bus.i_dbus_cyc = 1'b1;
    step();
    chk("rr1_adr", bus.o_wb_adr, 32'h200);
    slave_ack(32'h000000A1);
    chk("rr1_iack", 32'(bus.o_ibus_ack), 32'd1);
    chk("rr1_dack", 32'(bus.o_dbus_ack), 32'd0);
    step();
    chk("rr_resp_cyc", 32'(bus.o_wb_cyc), 32'd0);
    step();
    chk("rr2_adr", bus.o_wb_adr,      32'h3000);
    chk("rr2_cyc", 32'(bus.o_wb_cyc), 32'd1);
    slave_ack(32'h000000B2);
    chk("rr2_dack", 32'(bus.o_dbus_ack), 32'd1);
    chk("rr2_drdt", bus.o_dbus_rdt,      32'hB2);
    chk("rr2_iack", 32'(bus.o_ibus_ack), 32'd0);
    step();
    step();
    chk("rr3_adr", bus.o_wb_adr, 32'h200);
    slave_ack(32'h000000C3);
    bus.i_ibus_cyc = 1'b0; bus.i_dbus_cyc = 1'b0;
    chk("rr3_iack", 32'(bus.o_ibus_ack), 32'd1);
    chk("rr3_irdt", bus.o_ibus_rdt,      32'hC3);
    chk("rr3_drdt", bus.o_dbus_rdt,      32'hB2);
    step();
    step();

    // Watchdog: slave never acks
    bus.i_dbus_adr = 32'h40; bus.i_dbus_cyc = 1'b1;
    n_hi = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus.o_wb_cyc) n_hi++;
      if (bus.o_dbus_ack || bus.o_ibus_ack) break;
    end
    bus.i_dbus_cyc = 1'b0;
    chk("wd_cyc_len", 32'(n_hi),          32'd4);
    chk("wd_dack",    32'(bus.o_dbus_ack), 32'd1);
    chk("wd_err",     32'(bus.o_bus_err),  32'd1);
    chk("wd_rdt",     bus.o_dbus_rdt,      32'hDEADBEEF);
    step();
    chk("wd_err1",  32'(bus.o_bus_err),  32'd0);
    chk("wd_dack1", 32'(bus.o_dbus_ack), 32'd0);
    step();
    slave_ack(32'h77777777);
    chk("stray_dack", 32'(bus.o_dbus_ack), 32'd0);
    chk("stray_iack", 32'(bus.o_ibus_ack), 32'd0);
    chk("stray_cyc",  32'(bus.o_wb_cyc),   32'd0);
    step();
    chk("stray_dack2", 32'(bus.o_dbus_ack), 32'd0);
    chk("stray_drdt",  bus.o_dbus_rdt,      32'hDEADBEEF);

    // Ack on the expiry cycle wins
    bus.i_ibus_adr = 32'h80; bus.i_ibus_cyc = 1'b1;
    step();
    step();
    step();
    step();
    chk("exp_cyc4", 32'(bus.o_wb_cyc), 32'd1);
    slave_ack(32'h12345678);
    bus.i_ibus_cyc = 1'b0;
    chk("exp_iack", 32'(bus.o_ibus_ack), 32'd1);
    chk("exp_irdt", bus.o_ibus_rdt,      32'h12345678);
    chk("exp_err",  32'(bus.o_bus_err),  32'd0);
    step();
    step();

    // Reset mid-transaction
    bus.i_dbus_adr = 32'h44; bus.i_dbus_cyc = 1'b1;
    step();
    chk("mrst_pre", 32'(bus.o_wb_cyc), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst_cyc",  32'(bus.o_wb_cyc),   32'd0);
    chk("mrst_dack", 32'(bus.o_dbus_ack), 32'd0);
    chk("mrst_iack", 32'(bus.o_ibus_ack), 32'd0);
    chk("mrst_err",  32'(bus.o_bus_err),  32'd0);
    bus.i_dbus_cyc = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    step();
    chk("mrst_idle_cyc",  32'(bus.o_wb_cyc),   32'd0);
    chk("mrst_idle_dack", 32'(bus.o_dbus_ack), 32'd0);
    bus.i_ibus_adr = 32'h500; bus.i_ibus_cyc = 1'b1;
    bus.i_dbus_adr = 32'h600; bus.i_dbus_cyc = 1'b1;
    step();
    chk("mrst_tie_adr", bus.o_wb_adr, 32'h500);
    slave_ack(32'h0000ABCD);
    bus.i_ibus_cyc = 1'b0; bus.i_dbus_cyc = 1'b0;
    chk("mrst_tie_iack", 32'(bus.o_ibus_ack), 32'd1);
    step();
    step();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
